i2s_tx: RTL

- I2S transmitter that serializes 24-bit stereo samples onto SCK/WS/SD. Its framing is bit-compatible with the team's I2S microphone receiver.
- Used as a mic-array emulator for loopback testing of the capture/FFT path. Also drives an external audio DAC.
- Samples arrive from an upstream producer (HPS-fed tone generator) through a valid/ready handshake into a small internal FIFO.
- SCK and WS are generated internally from the 50 MHz system clock. Only one clock domain is used.

---
 rtl/i2s_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: stereo sample FIFO, SCK/WS divider, one-bit-delayed serializer.
module i2s_tx #(
  parameter int CLK_DIV    = 8,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [DATA_W-1:0]             left_in,
  input  logic [DATA_W-1:0]             right_in,
  output logic                          SCK,
  output logic                          WS,
  output logic                          SD,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SH_W  = 2 * DATA_W;
  localparam int IDX_W = $clog2(SH_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [SH_W-1:0]   shadow;
  logic [SH_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic              push;
  logic              pop;
  logic              div_wrap;
  logic              fall_evt;
  logic              frame_end;
  logic              load;
  logic [5:0]        next_bit;
  logic [IDX_W-1:0]  sd_idx;
  logic              next_sd;

  assign sample_ready = (count != LVL_W'(FIFO_DEPTH));
  assign push         = sample_valid && sample_ready;
  assign div_wrap     = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_evt     = div_wrap && SCK;
  assign next_bit     = bit_cnt + 6'd1;
  // A draining transmitter stops on the falling edge that closes bit 63 instead of loading a frame.
  assign frame_end    = fall_evt && (bit_cnt == 6'd63) && (state == DRAIN) && !enable;
  assign load         = fall_evt && (next_bit == 6'd0) && !frame_end;
  assign pop          = load && (count != '0);
  assign fifo_level   = count;

  always_comb begin
    next_sd = 1'b0;
    sd_idx  = '0;
    if (next_bit != 6'd0 && next_bit <= 6'(DATA_W)) begin
      sd_idx  = IDX_W'(SH_W - int'(next_bit));
      next_sd = shadow[sd_idx];
    end else if (next_bit >= 6'd33 && next_bit <= 6'(32 + DATA_W)) begin
      sd_idx  = IDX_W'(32 + DATA_W - int'(next_bit));
      next_sd = shadow[sd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {left_in, right_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= 6'd63;
      SCK         <= 1'b0;
      WS          <= 1'b0;
      SD          <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      shadow      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LVL_W'(push) - LVL_W'(pop);

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= 6'd63;
          SCK     <= 1'b0;
          WS      <= 1'b0;
          SD      <= 1'b0;
          if (enable) state <= RUN;
        end
        default: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) SCK <= ~SCK;
          if (frame_end) begin
            state <= IDLE;
            WS    <= 1'b0;
            SD    <= 1'b0;
          end else begin
            if (state == RUN && !enable)      state <= DRAIN;
            else if (state == DRAIN && enable) state <= RUN;
            if (fall_evt) begin
              bit_cnt <= next_bit;
              WS      <= next_bit[5];
              SD      <= next_sd;
            end
            if (load) begin
              frame_start <= 1'b1;
              if (count != '0) begin
                shadow <= mem[rd_ptr];
              end else begin
                shadow   <= '0;
                underrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end
endmodule
